// File: rtl/demux32bit_1to2_buf_pkg.sv
// Shared datapath constants for the buffered 1-to-2 word demultiplexer.
package demux32bit_1to2_buf_pkg;
  localparam int   WORD_W = 32;
  localparam logic CH0    = 1'b0;
  localparam logic CH1    = 1'b1;
endpackage

// File: rtl/demux32bit_1to2_buf_fifo.sv
// Small synchronous FIFO with occupancy count; head word reads 0 while empty.
module demux_fifo
  import demux32bit_1to2_buf_pkg::*;
#(
  parameter  int WIDTH = WORD_W,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH) + 1,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign push  = wr_en & ~full;
  assign pop   = rd_en & ~empty;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/demux32bit_1to2_buf.sv
// Buffered 1-to-2 word demultiplexer: steers each producer word into one of
// two independent FIFOs, each with its own valid/ready consumer handshake.
module demux32bit_1to2_buf
  import demux32bit_1to2_buf_pkg::*;
#(
  parameter  int WIDTH = WORD_W,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i,
  input  logic             s,
  input  logic             i_valid,
  output logic             i_ready,
  output logic [WIDTH-1:0] z0,
  output logic             z0_valid,
  input  logic             z0_ready,
  output logic [WIDTH-1:0] z1,
  output logic             z1_valid,
  input  logic             z1_ready,
  output logic [CW-1:0]    z0_count,
  output logic [CW-1:0]    z1_count
);

  logic wr_en0, wr_en1, rd_en0, rd_en1;
  logic empty0, empty1, full0, full1;

  // Backpressure depends only on the selected channel's registered fill level.
  assign i_ready  = (s == CH1) ? ~full1 : ~full0;
  assign wr_en0   = i_valid & i_ready & (s == CH0);
  assign wr_en1   = i_valid & i_ready & (s == CH1);
  assign z0_valid = ~empty0;
  assign z1_valid = ~empty1;
  assign rd_en0   = z0_valid & z0_ready;
  assign rd_en1   = z1_valid & z1_ready;

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en0),
    .wr_data (i),
    .rd_en   (rd_en0),
    .rd_data (z0),
    .empty   (empty0),
    .full    (full0),
    .count   (z0_count)
  );

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en1),
    .wr_data (i),
    .rd_en   (rd_en1),
    .rd_data (z1),
    .empty   (empty1),
    .full    (full1),
    .count   (z1_count)
  );

endmodule

// File: tb/tb_demux32bit_1to2_buf.sv
// Directed bench for the buffered 1-to-2 demultiplexer.
module tb_demux32bit_1to2_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i;
  logic        s;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] z0, z1;
  logic        z0_valid, z1_valid;
  logic        z0_ready, z1_ready;
  logic [1:0]  z0_count, z1_count;

  int checks   = 0;
  int failures = 0;

  demux32bit_1to2_buf dut (
    .clk      (clk),
    .reset    (reset),
    .i        (i),
    .s        (s),
    .i_valid  (i_valid),
    .i_ready  (i_ready),
    .z0       (z0),
    .z0_valid (z0_valid),
    .z0_ready (z0_ready),
    .z1       (z1),
    .z1_valid (z1_valid),
    .z1_ready (z1_ready),
    .z0_count (z0_count),
    .z1_count (z1_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic ch, input logic [31:0] data);
    i       = data;
    s       = ch;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
  endtask

  initial begin
    int  p, c, mc;
    bit  pu, po, tog;

    reset = 1'b1; i = '0; s = 1'b0; i_valid = 1'b0; z0_ready = 1'b0; z1_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    check_eq("rst_z0_valid", 32'(z0_valid), 32'd0);
    check_eq("rst_z1_valid", 32'(z1_valid), 32'd0);
    check_eq("rst_z0",       z0, 32'd0);
    check_eq("rst_z1",       z1, 32'd0);
    check_eq("rst_z0_count", 32'(z0_count), 32'd0);
    check_eq("rst_z1_count", 32'(z1_count), 32'd0);
    check_eq("rst_i_ready",  32'(i_ready), 32'd1);

    // single routing
    push_word(1'b0, 32'hDEADBEEF);
    check_eq("r0_data",     z0, 32'hDEADBEEF);
    check_eq("r0_valid",    32'(z0_valid), 32'd1);
    check_eq("r0_count",    32'(z0_count), 32'd1);
    check_eq("r0_z1_valid", 32'(z1_valid), 32'd0);
    push_word(1'b1, 32'h12345678);
    check_eq("r1_data",  z1, 32'h12345678);
    check_eq("r1_valid", 32'(z1_valid), 32'd1);
    check_eq("r1_count", 32'(z1_count), 32'd1);
    z0_ready = 1'b1; z1_ready = 1'b1;
    tick();
    z0_ready = 1'b0; z1_ready = 1'b0;
    check_eq("drain_z0_count", 32'(z0_count), 32'd0);
    check_eq("drain_z1_count", 32'(z1_count), 32'd0);
    check_eq("drain_z0_zero",  z0, 32'd0);

    // fill and backpressure
    push_word(1'b0, 32'h1);
    push_word(1'b0, 32'h2);
    s = 1'b0; #1;
    check_eq("full_rdy_s0", 32'(i_ready), 32'd0);
    s = 1'b1; #1;
    check_eq("full_rdy_s1", 32'(i_ready), 32'd1);
    push_word(1'b0, 32'h3);
    check_eq("full_refused_cnt",  32'(z0_count), 32'd2);
    check_eq("full_refused_head", z0, 32'h1);
    z0_ready = 1'b1;
    tick();
    check_eq("drain_head2", z0, 32'h2);
    check_eq("drain_cnt1",  32'(z0_count), 32'd1);
    tick();
    check_eq("drain_cnt0",  32'(z0_count), 32'd0);
    check_eq("drain_valid", 32'(z0_valid), 32'd0);
    z0_ready = 1'b0;

    // simultaneous push/pop on channel 1
    push_word(1'b1, 32'h0BADF00D);
    i = 32'hA5A5A5A5; s = 1'b1; i_valid = 1'b1; z1_ready = 1'b1;
    tick();
    i_valid = 1'b0; z1_ready = 1'b0;
    check_eq("pp_count", 32'(z1_count), 32'd1);
    check_eq("pp_head",  z1, 32'hA5A5A5A5);
    z1_ready = 1'b1;
    tick();
    z1_ready = 1'b0;
    check_eq("pp_drained", 32'(z1_count), 32'd0);

    // pointer wrap with toggling consumer
    p = 0; c = 0; mc = 0; tog = 1'b0;
    for (int cyc = 0; cyc < 60 && c < 10; cyc++) begin
      i_valid = (p < 10); i = 32'(p); s = 1'b0; z0_ready = tog; tog = ~tog;
      #1;
      pu = i_valid && i_ready;
      po = z0_valid && z0_ready;
      if (po) begin
        check_eq("wrap_order", z0, 32'(c));
        c++;
      end
      if (pu) p++;
      mc = mc + int'(pu) - int'(po);
      tick();
      check_eq("wrap_count", 32'(z0_count), 32'(mc));
    end
    i_valid = 1'b0; z0_ready = 1'b0;
    check_eq("wrap_done", 32'(c), 32'd10);

    // asynchronous reset with both channels full
    push_word(1'b0, 32'hC0);
    push_word(1'b0, 32'hC1);
    push_word(1'b1, 32'hD0);
    push_word(1'b1, 32'hD1);
    check_eq("pre_rst_cnt0", 32'(z0_count), 32'd2);
    check_eq("pre_rst_cnt1", 32'(z1_count), 32'd2);
    #1 reset = 1'b1;
    #1;
    check_eq("arst_z0_valid", 32'(z0_valid), 32'd0);
    check_eq("arst_z1_valid", 32'(z1_valid), 32'd0);
    check_eq("arst_cnt0",     32'(z0_count), 32'd0);
    check_eq("arst_cnt1",     32'(z1_count), 32'd0);
    check_eq("arst_z0",       z0, 32'd0);
    #1 reset = 1'b0;
    tick();
    push_word(1'b0, 32'h77);
    check_eq("post_rst_head", z0, 32'h77);
    check_eq("post_rst_cnt",  32'(z0_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
